// File: rtl/rdy_vld_rr_merge_if.sv
// Handshake bundle for the N-channel round-robin merge.
// slave: the merge block; master: producers plus consumer.
interface rdy_vld_rr_merge_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_vld;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_rdy;
  logic                     out_vld;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_rdy;
  logic [NUM_CH-1:0]        ch_full;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data,
    input  out_ch, ch_full
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data,
    output out_ch, ch_full
  );
endinterface

// File: rtl/rdy_vld_rr_merge.sv
// N-channel ready/valid merge: per-channel FIFOs feeding a
// round-robin arbiter into one registered, channel-tagged output.
module rdy_vld_rr_merge #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst_n,
  rdy_vld_rr_merge_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [AW-1:0]     rd_ptr_q [NUM_CH];
  logic [AW-1:0]     wr_ptr_q [NUM_CH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  logic [NUM_CH-1:0] in_rdy_q, in_rdy_d;
  logic [NUM_CH-1:0] ch_full_q, ch_full_d;
  logic [NUM_CH-1:0] push, pop, nonempty;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              load;

  // Only beats resident at cycle start are eligible, so a
  // freshly pushed beat never passes straight through.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c] = cnt_q[c] != '0;
      push[c]     = bus.in_vld[c] & in_rdy_q[c];
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end
  end

  assign load = (!out_vld_q || bus.out_rdy) && found;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]       = load && (grant == CH_W'(c));
      cnt_d[c]     = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      in_rdy_d[c]  = cnt_d[c] < FULL;
      ch_full_d[c] = cnt_d[c] == FULL;
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    last_d     = last_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = mem_q[grant][rd_ptr_q[grant]];
      out_ch_d   = grant;
      last_d     = grant;
    end else if (bus.out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[c][j] <= '0;
        end
      end
      in_rdy_q   <= '0;
      ch_full_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      last_q     <= CH_W'(NUM_CH - 1);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) begin
          mem_q[c][wr_ptr_q[c]] <=
            bus.in_data[c*DATA_W +: DATA_W];
          wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        end
        cnt_q[c] <= cnt_d[c];
      end
      in_rdy_q   <= in_rdy_d;
      ch_full_q  <= ch_full_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      last_q     <= last_d;
    end
  end

  assign bus.in_rdy   = in_rdy_q;
  assign bus.ch_full  = ch_full_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_ch   = out_ch_q;
endmodule

// File: tb/tb_rdy_vld_rr_merge.sv
// Scoreboard bench for rdy_vld_rr_merge: per-channel data
// queues plus a hand-computed channel-order queue.
module tb_rdy_vld_rr_merge;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rdy_vld_rr_merge_if #(.NUM_CH(NC), .DATA_W(DW)) bus ();

  rdy_vld_rr_merge #(
    .NUM_CH(NC), .DATA_W(DW), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [DW-1:0] exp_q [NC][$];
  int            exp_ch [$];
  int            seq [NC];
  int            acc [NC];

  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic [1:0]    hold_c;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int left();
    int s = 0;
    for (int c = 0; c < NC; c++) s += exp_q[c].size();
    return s;
  endfunction

  // Monitor: checks transfers, stall stability, records accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_vld", bus.out_vld, 1);
        check("hold_data", bus.out_data, hold_d);
        check("hold_ch", bus.out_ch, hold_c);
      end
      hold_pend = bus.out_vld && !bus.out_rdy;
      hold_d    = bus.out_data;
      hold_c    = bus.out_ch;
      if (bus.out_vld && bus.out_rdy) begin
        n_out++;
        total++;
        if (exp_q[bus.out_ch].size() == 0) begin
          bad++;
          $display("FAIL spurious: got ch %0d data %0h want none",
                   bus.out_ch, bus.out_data);
        end else begin
          total--;
          check("out_data", bus.out_data,
                exp_q[bus.out_ch].pop_front());
        end
        if (exp_ch.size() != 0)
          check("out_ch", bus.out_ch, exp_ch.pop_front());
      end
      for (int c = 0; c < NC; c++)
        if (bus.in_vld[c] && bus.in_rdy[c])
          exp_q[c].push_back(bus.in_data[c*DW +: DW]);
    end
  end

  task automatic set_data();
    for (int c = 0; c < NC; c++)
      bus.in_data[c*DW +: DW] = {8'(c), 24'(seq[c] + 1)};
  endtask

  task automatic clear_sb();
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete();
      seq[c] = 0;
      acc[c] = 0;
    end
    exp_ch.delete();
    set_data();
  endtask

  // Called just after a rising edge; leaves us just after one.
  task automatic do_reset();
    check("chseq_left", exp_ch.size(), 0);
    bus.in_vld  = '0;
    bus.out_rdy = 1'b0;
    rst_n = 1'b0;
    clear_sb();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", bus.in_rdy, {NC{1'b1}});
  endtask

  task automatic step(input logic [NC-1:0] v, input logic ordy);
    bus.in_vld  = v;
    bus.out_rdy = ordy;
    @(negedge clk);
    for (int c = 0; c < NC; c++)
      if (v[c] && bus.in_rdy[c]) begin
        acc[c]++;
        seq[c]++;
      end
    @(posedge clk);
    #1;
    set_data();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    bus.in_vld  = '0;
    bus.out_rdy = 1'b1;
    while (left() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_left", left(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_vld", bus.out_vld, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_vld  = '0;
    bus.out_rdy = 1'b0;
    clear_sb();
    #1;
    check("rst_in_rdy", bus.in_rdy, 0);
    check("rst_full", bus.ch_full, 0);
    check("rst_vld", bus.out_vld, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_ch", bus.out_ch, 0);
    do_reset();

    // Single beat latency on ch2.
    bus.out_rdy = 1'b1;
    bus.in_data[2*DW +: DW] = 32'hA5A5A5A5;
    bus.in_vld = 4'b0100;
    exp_ch.push_back(2);
    @(posedge clk); #1;
    bus.in_vld = '0;
    check("lat_e0_vld", bus.out_vld, 0);
    @(posedge clk); #1;
    check("lat_e1_vld", bus.out_vld, 1);
    check("lat_e1_data", bus.out_data, 32'hA5A5A5A5);
    check("lat_e1_ch", bus.out_ch, 2);
    @(posedge clk); #1;
    check("lat_e2_vld", bus.out_vld, 0);
    drain(20);

    // Fill to capacity on ch0 with the output stalled.
    do_reset();
    repeat (5) exp_ch.push_back(0);
    repeat (8) step(4'b0001, 1'b0);
    check("fill_acc", acc[0], 5);
    check("fill_rdy0", bus.in_rdy[0], 0);
    check("fill_full0", bus.ch_full[0], 1);
    check("fill_vld", bus.out_vld, 1);
    check("fill_data", bus.out_data, 1);
    drain(40);
    check("fill_rdy0_after", bus.in_rdy[0], 1);
    check("fill_full0_after", bus.ch_full[0], 0);

    // Saturation: strict 0,1,2,3 rotation, no gaps.
    do_reset();
    for (int i = 0; i < 16; i++) exp_ch.push_back(i % 4);
    for (int i = 0; i < 18; i++) begin
      step(4'b1111, 1'b1);
      if (i == 0) check("sat_vld0", bus.out_vld, 0);
      else        check("sat_gap", bus.out_vld, 1);
    end
    drain(80);

    // Sparse: ch1+ch3 alternate, then ch3 alone.
    do_reset();
    exp_ch.push_back(1); exp_ch.push_back(3);
    exp_ch.push_back(1); exp_ch.push_back(3);
    exp_ch.push_back(3); exp_ch.push_back(3);
    exp_ch.push_back(3);
    repeat (2) step(4'b1010, 1'b1);
    repeat (3) step(4'b1000, 1'b1);
    drain(40);

    // Random traffic and backpressure.
    do_reset();
    for (int i = 0; i < 1000; i++)
      step(NC'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain(200);

    // Mid-operation reset with 3 channels buffered.
    do_reset();
    repeat (3) step(4'b0111, 1'b0);
    check("mid_pre_vld", bus.out_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_vld", bus.out_vld, 0);
    check("mid_rdy", bus.in_rdy, 0);
    check("mid_full", bus.ch_full, 0);
    check("mid_data", bus.out_data, 0);
    check("mid_ch", bus.out_ch, 0);
    clear_sb();
    bus.in_vld  = '0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("mid_idle", bus.out_vld, 0);
    end
    exp_ch.push_back(1);
    exp_ch.push_back(3);
    step(4'b1010, 1'b1);
    drain(20);

    check("chseq_end", exp_ch.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
